// File: rtl/ahbl_sram_slave.sv
// AHB-Lite slave in front of a word-organised on-chip RAM, with programmable
// wait states, a two-cycle ERROR response and a write-to-read bypass.
module ahbl_sram_slave #(
  parameter int AW          = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int WW    = AW - 2;
  localparam int DEPTH = 2 ** WW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t state, state_nxt;
  logic [3:0]    wcnt, wcnt_nxt;

  logic [AW-1:0] addr_p1;
  logic [2:0]    size_p1;
  logic          write_p1;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   hrdata_p2, hrdata_nxt;

  logic          accept, take, bad, wr_now;
  logic          rd_fresh, rd_late;
  logic [WW-1:0] rd_idx, wr_idx;
  logic [3:0]    be_p1;
  logic [31:0]   rd_word;

  logic          unused_bits;
  assign unused_bits = ^{hburst, haddr[31:AW]};

  function automatic logic size_err(input logic [2:0] sz, input logic [1:0] a);
    case (sz)
      3'd0:    size_err = 1'b0;
      3'd1:    size_err = a[0];
      3'd2:    size_err = |a;
      default: size_err = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_en(input logic [2:0] sz, input logic [1:0] a);
    case (sz)
      3'd0:    lane_en = 4'b0001 << a;
      3'd1:    lane_en = a[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  be);
    merge = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merge[8*i +: 8] = new_w[8*i +: 8];
    end
  endfunction

  // Address phase: a beat can only be taken while no data phase is stalling
  assign accept = hsel & htrans[1] & hready;
  assign take   = accept & (state == S_IDLE || state == S_DATA || state == S_ERR2);
  assign bad    = size_err(hsize, haddr[1:0]);

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      S_WAIT: begin
        wcnt_nxt = wcnt - 4'd1;
        if (wcnt <= 4'd1) state_nxt = S_DATA;
      end
      S_ERR1: state_nxt = S_ERR2;
      default: begin
        if (take) begin
          if (bad) begin
            state_nxt = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            wcnt_nxt  = 4'(WAIT_STATES);
          end else begin
            state_nxt = S_DATA;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wcnt     <= 4'd0;
      write_p1 <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (take) write_p1 <= hwrite & ~bad;
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      addr_p1 <= haddr[AW-1:0];
      size_p1 <= hsize;
    end
  end

  // Data phase: the write lands on the edge that ends DATA
  assign be_p1  = lane_en(size_p1, addr_p1[1:0]);
  assign wr_now = (state == S_DATA) & write_p1;
  assign wr_idx = addr_p1[AW-1:2];

  always_ff @(posedge clk) begin
    if (rst_n && wr_now) begin
      for (int i = 0; i < 4; i++) begin
        if (be_p1[i]) mem[wr_idx][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  // Read word is registered on the edge entering DATA; a write retiring on
  // that same edge to the same word is merged in so the read sees it.
  assign rd_fresh = take & ~bad & ~hwrite & (WAIT_STATES == 0);
  assign rd_late  = (state == S_WAIT) & (wcnt <= 4'd1) & ~write_p1;
  assign rd_idx   = rd_fresh ? haddr[AW-1:2] : addr_p1[AW-1:2];
  assign rd_word  = mem[rd_idx];

  always_comb begin
    hrdata_nxt = 32'd0;
    if (rd_fresh || rd_late) begin
      if (wr_now && (wr_idx == rd_idx)) hrdata_nxt = merge(rd_word, hwdata, be_p1);
      else                              hrdata_nxt = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) hrdata_p2 <= 32'd0;
    else        hrdata_p2 <= hrdata_nxt;
  end

  assign hreadyout = ~(state == S_WAIT || state == S_ERR1);
  assign hresp     = (state == S_ERR1) || (state == S_ERR2);
  assign hrdata    = hrdata_p2;

endmodule
